// File: rtl/radix4_pkg.sv
// Shared encodings for the radix-4 Booth multiplier: FSM states and partial-product select codes.
package radix4_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      SEL_ZERO = 3'd0,
      SEL_PA   = 3'd1,
      SEL_P2A  = 3'd2,
      SEL_MA   = 3'd3,
      SEL_M2A  = 3'd4
   } sel_t;

   // Group is {b[i+1], b[i], b[i-1]}; standard radix-4 recoding.
   function automatic sel_t booth_sel(input logic [2:0] g);
      sel_t s;
      case (g)
         3'b001, 3'b010: s = SEL_PA;
         3'b011:         s = SEL_P2A;
         3'b100:         s = SEL_M2A;
         3'b101, 3'b110: s = SEL_MA;
         default:        s = SEL_ZERO;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/radix4_booth_encoder.sv
// Radix-4 Booth partial-product generator: maps a 3-bit group and A to 0, +-A or +-2A.
// Purely combinational, no handshake.
module radix4_booth_encoder
   import radix4_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       grp,
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH+1:0] pp
);

   logic [WIDTH+1:0] a1;
   logic [WIDTH+1:0] a2;

   // Two guard bits keep -2A of the most negative A representable.
   assign a1 = {{2{a[WIDTH-1]}}, a};
   assign a2 = {a[WIDTH-1], a, 1'b0};

   always_comb begin
      pp = '0;
      case (booth_sel(grp))
         SEL_PA:  pp = a1;
         SEL_P2A: pp = a2;
         SEL_MA:  pp = -a1;
         SEL_M2A: pp = -a2;
         default: pp = '0;
      endcase
   end

endmodule

// File: rtl/radix4_booth_seq.sv
// Sequential signed radix-4 Booth multiplier, two multiplier bits retired per clock.
// Latency: start accepted at edge 0, done pulses after edge WIDTH/2; starts outside IDLE are dropped.
module radix4_booth_seq
   import radix4_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int N_ITER = WIDTH / 2;
   localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
   localparam int ACC_W  = WIDTH + 2;
   localparam int SR_W   = ACC_W + WIDTH + 1;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   low_q, low_d;
   logic               extra_q, extra_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_d, done_d;
   logic [2*WIDTH-1:0] product_d;

   logic [ACC_W-1:0]        pp;
   logic [ACC_W-1:0]        sum;
   logic signed [SR_W-1:0]  sr_cat;
   logic signed [SR_W-1:0]  sr_shr;
   logic [ACC_W-1:0]        acc_n;
   logic [WIDTH-1:0]        low_n;
   logic                    last_iter;

   radix4_booth_encoder #(.WIDTH(WIDTH)) u_enc (
      .grp ({low_q[1:0], extra_q}),
      .a   (a_q),
      .pp  (pp)
   );

   assign sum       = acc_q + pp;
   assign sr_cat    = {sum, low_q, extra_q};
   assign sr_shr    = sr_cat >>> 2;
   assign acc_n     = sr_shr[SR_W-1 -: ACC_W];
   assign low_n     = sr_shr[WIDTH:1];
   assign last_iter = (cnt_q == CNT_W'(N_ITER - 1));

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      acc_d     = acc_q;
      low_d     = low_q;
      extra_d   = extra_q;
      cnt_d     = cnt_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      product_d = product;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = multiplicand;
               acc_d   = '0;
               low_d   = multiplier;
               extra_d = 1'b0;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            acc_d   = acc_n;
            low_d   = low_n;
            extra_d = sr_shr[0];
            cnt_d   = cnt_q + CNT_W'(1);
            busy_d  = !last_iter;
            if (last_iter) begin
               product_d = {acc_n[WIDTH-1:0], low_n};
               done_d    = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         acc_q   <= '0;
         low_q   <= '0;
         extra_q <= 1'b0;
         cnt_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         acc_q   <= acc_d;
         low_q   <= low_d;
         extra_q <= extra_d;
         cnt_q   <= cnt_d;
         busy    <= busy_d;
         done    <= done_d;
         product <= product_d;
      end
   end

endmodule

// File: tb/tb_radix4_booth_seq.sv
// Directed bench for radix4_booth_seq: stimulus pushes expected products, a monitor pops them on done.
module tb_radix4_booth_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  multiplicand;
   logic [7:0]  multiplier;
   logic        busy;
   logic        done;
   logic [15:0] product;

   int          checks;
   int          failures;
   int          done_cnt;
   logic [15:0] sb[$];
   logic [15:0] held;
   logic        prev_done;
   bit          tb_end;

   radix4_booth_seq #(.WIDTH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      while (!tb_end) begin
         @(negedge clk);
         if (reset) begin
            held      = 16'h0000;
            prev_done = 1'b0;
         end else if (done) begin
            done_cnt++;
            check("done_single_pulse", {31'd0, prev_done}, 32'd0);
            check("busy_low_at_done", {31'd0, busy}, 32'd0);
            if (sb.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               check("product", {16'd0, product}, {16'd0, sb.pop_front()});
            end
            held      = product;
            prev_done = 1'b1;
         end else begin
            check("product_hold", {16'd0, product}, {16'd0, held});
            prev_done = 1'b0;
         end
      end
   endtask

   // Called at a negedge with the DUT in IDLE; returns at the negedge after the done cycle.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
      bit seen;
      multiplicand = a;
      multiplier   = b;
      start        = 1'b1;
      sb.push_back(exp);
      @(negedge clk);
      start        = 1'b0;
      multiplicand = 8'hA5;
      multiplier   = 8'h3C;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) check("done_timeout", 32'd1, 32'd0);
      @(negedge clk);
   endtask

   task automatic stimulus();
      int base;
      bit seen;
      // Reset held three cycles, then idle with no start.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_outputs", {15'd0, busy, done, product}, 32'd0);
      end
      @(posedge clk);
      #2 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_outputs", {15'd0, busy, done, product}, 32'd0);
      end

      // 3 * 5 with busy timing: low after acceptance edge, high after edges 1..3.
      multiplicand = 8'd3;
      multiplier   = 8'd5;
      start        = 1'b1;
      sb.push_back(16'h000F);
      @(negedge clk);
      start = 1'b0;
      check("busy_after_accept", {31'd0, busy}, 32'd0);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         check("busy_run", {31'd0, busy}, 32'd1);
      end
      @(negedge clk);
      check("done_after_edge4", {31'd0, done}, 32'd1);
      check("busy_clear_edge4", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("done_cleared", {31'd0, done}, 32'd0);

      run_op(8'hF9, 8'd6,  16'hFFD6);
      run_op(8'h7F, 8'h80, 16'hC080);
      run_op(8'h80, 8'h80, 16'h4000);
      run_op(8'd0,  8'd99, 16'h0000);

      // Second start during RUN must be dropped.
      base = done_cnt;
      multiplicand = 8'd3;
      multiplier   = 8'd5;
      start        = 1'b1;
      sb.push_back(16'h000F);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      multiplicand = 8'd9;
      multiplier   = 8'd9;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      check("ignored_start_pulses", done_cnt - base, 32'd1);
      run_op(8'd9, 8'd9, 16'h0051);

      // Asynchronous reset two edges into a run.
      base = done_cnt;
      multiplicand = 8'd3;
      multiplier   = 8'd5;
      start        = 1'b1;
      sb.push_back(16'h000F);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("async_reset_outputs", {15'd0, busy, done, product}, 32'd0);
      sb.delete();
      @(posedge clk);
      #2 reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      check("no_done_after_reset", {31'd0, seen}, 32'd0);
      check("no_done_count_after_reset", done_cnt - base, 32'd0);
      run_op(8'd2, 8'd3, 16'h0006);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb.size(), 32'd0);
      tb_end = 1'b1;
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      done_cnt     = 0;
      held         = 16'h0000;
      prev_done    = 1'b0;
      tb_end       = 1'b0;
      reset        = 1'b1;
      start        = 1'b0;
      multiplicand = 8'd0;
      multiplier   = 8'd0;
      fork
         monitor();
         stimulus();
      join
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
